waveform_line_sequencer: RTL and testbench

- Upstream driver for the line rasteriser.
- Consumes a stream of signed audio samples and maps each sample to a screen point (x = column index, y = scaled amplitude).
- Issues one line request per consecutive point pair, over a four-phase start/done handshake, so the rasteriser draws a continuous oscilloscope trace across one frame.
- Sits between the audio sample source and the rasteriser.

---
 rtl/waveform_line_sequencer_if.sv | 28 ++
 rtl/waveform_line_sequencer.sv | 156 +++++++++++++++
 tb/tb_waveform_line_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_line_sequencer_if.sv
// rtl/waveform_line_sequencer_if.sv - sample stream in, line request/done handshake out, frame status
interface waveform_line_sequencer_if #(
    parameter int SAMPLE_WIDTH  = 24,
    parameter int COUNTER_WIDTH = 10
);
    logic                     frame_start;
    logic [SAMPLE_WIDTH-1:0]  sample_data;
    logic                     sample_valid;
    logic                     sample_ready;
    logic                     line_start;
    logic [COUNTER_WIDTH-1:0] x1;
    logic [COUNTER_WIDTH-1:0] y1;
    logic [COUNTER_WIDTH-1:0] x2;
    logic [COUNTER_WIDTH-1:0] y2;
    logic                     line_done;
    logic                     busy;
    logic                     frame_done;

    modport master (
        input  frame_start, sample_data, sample_valid, line_done,
        output sample_ready, line_start, x1, y1, x2, y2, busy, frame_done
    );

    modport slave (
        output frame_start, sample_data, sample_valid, line_done,
        input  sample_ready, line_start, x1, y1, x2, y2, busy, frame_done
    );
endinterface

// File: rtl/waveform_line_sequencer.sv
// rtl/waveform_line_sequencer.sv - maps audio samples to screen points and requests one line per point pair
module waveform_line_sequencer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int SAMPLE_WIDTH  = 24,
    parameter int COUNTER_WIDTH = $clog2(SCREEN_WIDTH),
    parameter int X_STEP        = 1,
    parameter int AMP_SHIFT     = SAMPLE_WIDTH - 8
) (
    input  logic                      clk,
    input  logic                      reset,
    waveform_line_sequencer_if.master bus
);
    localparam int CW = COUNTER_WIDTH;
    // Wide enough that no sample value can wrap the subtraction before clamping.
    localparam int MW = SAMPLE_WIDTH + COUNTER_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SAMPLE,
        S_MAP,
        S_ISSUE,
        S_WAIT_LOW,
        S_DONE
    } state_t;

    state_t                         state_q;
    logic signed [SAMPLE_WIDTH-1:0] sample_q;
    logic                           first_q;
    logic [CW:0]                    col_q;
    logic [CW-1:0]                  prev_x_q;
    logic [CW-1:0]                  prev_y_q;
    logic [CW-1:0]                  x1_q;
    logic [CW-1:0]                  y1_q;
    logic [CW-1:0]                  x2_q;
    logic [CW-1:0]                  y2_q;
    logic                           sample_ready_q;
    logic                           line_start_q;
    logic                           busy_q;
    logic                           frame_done_q;

    logic signed [SAMPLE_WIDTH-1:0] amp;
    logic signed [MW-1:0]           yv;
    logic [CW-1:0]                  map_y;
    logic [CW:0]                    next_col;
    logic                           end_of_frame;

    assign amp = sample_q >>> AMP_SHIFT;
    assign yv  = MW'(SCREEN_HEIGHT / 2) - {{(MW-SAMPLE_WIDTH){amp[SAMPLE_WIDTH-1]}}, amp};

    always_comb begin
        map_y = yv[CW-1:0];
        if (yv[MW-1]) begin
            map_y = '0;
        end else if ($unsigned(yv) > MW'(SCREEN_HEIGHT - 1)) begin
            map_y = CW'(SCREEN_HEIGHT - 1);
        end
    end

    // col_q equals x2 while waiting for done to fall; the extra bit keeps the sum from wrapping.
    assign next_col     = col_q + (CW+1)'(X_STEP);
    assign end_of_frame = next_col > (CW+1)'(SCREEN_WIDTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sample_q       <= '0;
            first_q        <= 1'b0;
            col_q          <= '0;
            prev_x_q       <= '0;
            prev_y_q       <= '0;
            x1_q           <= '0;
            y1_q           <= '0;
            x2_q           <= '0;
            y2_q           <= '0;
            sample_ready_q <= 1'b0;
            line_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        col_q          <= '0;
                        first_q        <= 1'b1;
                        busy_q         <= 1'b1;
                        sample_ready_q <= 1'b1;
                        state_q        <= S_WAIT_SAMPLE;
                    end
                end
                S_WAIT_SAMPLE: begin
                    if (bus.sample_valid) begin
                        sample_q       <= bus.sample_data;
                        sample_ready_q <= 1'b0;
                        state_q        <= S_MAP;
                    end
                end
                S_MAP: begin
                    if (first_q) begin
                        // The first point of a frame only seeds the trace.
                        prev_x_q       <= '0;
                        prev_y_q       <= map_y;
                        first_q        <= 1'b0;
                        col_q          <= (CW+1)'(X_STEP);
                        sample_ready_q <= 1'b1;
                        state_q        <= S_WAIT_SAMPLE;
                    end else begin
                        x1_q         <= prev_x_q;
                        y1_q         <= prev_y_q;
                        x2_q         <= col_q[CW-1:0];
                        y2_q         <= map_y;
                        line_start_q <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.line_done) begin
                        line_start_q <= 1'b0;
                        state_q      <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    if (!bus.line_done) begin
                        prev_x_q <= x2_q;
                        prev_y_q <= y2_q;
                        if (end_of_frame) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= S_DONE;
                        end else begin
                            col_q          <= next_col;
                            sample_ready_q <= 1'b1;
                            state_q        <= S_WAIT_SAMPLE;
                        end
                    end
                end
                S_DONE: begin
                    frame_done_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sample_ready = sample_ready_q;
    assign bus.line_start   = line_start_q;
    assign bus.x1           = x1_q;
    assign bus.y1           = y1_q;
    assign bus.x2           = x2_q;
    assign bus.y2           = y2_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_waveform_line_sequencer.sv
// tb/tb_waveform_line_sequencer.sv - bench for waveform_line_sequencer: default frame and a stepped narrow screen
module tb_waveform_line_sequencer;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    waveform_line_sequencer_if #(.SAMPLE_WIDTH(24), .COUNTER_WIDTH(10)) bus_a ();
    waveform_line_sequencer_if #(.SAMPLE_WIDTH(24), .COUNTER_WIDTH(4))  bus_b ();

    waveform_line_sequencer dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.master)
    );

    waveform_line_sequencer #(
        .SCREEN_WIDTH  (16),
        .SCREEN_HEIGHT (16),
        .X_STEP        (4),
        .AMP_SHIFT     (0)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.master)
    );

    typedef struct packed {
        logic [9:0] x1;
        logic [9:0] y1;
        logic [9:0] x2;
        logic [9:0] y2;
    } line_t;

    typedef struct {
        logic [23:0] sample;
        int          exp_y;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    line_t exp_a[$];
    line_t exp_b[$];

    int    a_first, a_col, a_px, a_py;
    int    b_first, b_col, b_px, b_py;
    int    ras_hold_a = 1, ras_cnt_a = 0, lines_a = 0, fd_a = 0, xfer_cyc_a = 0, last_x2_a = 0;
    int    ras_cnt_b = 0, lines_b = 0, fd_b = 0;
    bit    ras_en_a = 1'b1, lat_chk_a = 1'b0, ls_prev_a = 1'b0, ls_prev_b = 1'b0;
    line_t cur_a, cur_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input line_t got, input line_t exp);
        chk({name, ".x1"}, 64'(got.x1), 64'(exp.x1));
        chk({name, ".y1"}, 64'(got.y1), 64'(exp.y1));
        chk({name, ".x2"}, 64'(got.x2), 64'(exp.x2));
        chk({name, ".y2"}, 64'(got.y2), 64'(exp.y2));
    endtask

    function automatic int model_y(input logic [23:0] d, input int sh, input int h);
        int v;
        v = {{8{d[23]}}, d};
        v = v >>> sh;
        v = h / 2 - v;
        if (v < 0) v = 0;
        if (v > h - 1) v = h - 1;
        return v;
    endfunction

    task automatic note_xfer(input int ey, input int step, inout int first, inout int col,
                             inout int px, inout int py, output bit push, output line_t ln);
        push = 1'b0;
        ln   = '0;
        if (first != 0) begin
            px = 0; py = ey; col = step; first = 0;
        end else begin
            push = 1'b1;
            ln   = '{x1: 10'(px), y1: 10'(py), x2: 10'(col), y2: 10'(ey)};
            px   = col; py = ey; col = col + step;
        end
    endtask

    task automatic send_a(input logic [23:0] d, input int ey, input int stall);
        int    guard = 0;
        bit    push;
        line_t ln;
        repeat (stall) @(negedge clk);
        bus_a.sample_data  = d;
        bus_a.sample_valid = 1'b1;
        while (!bus_a.sample_ready && guard < 200) begin @(negedge clk); guard++; end
        chk("a_ready_wait", 64'(guard < 200), 64'd1);
        if (guard >= 200) begin bus_a.sample_valid = 1'b0; return; end
        @(negedge clk);
        xfer_cyc_a         = cyc;
        bus_a.sample_valid = 1'b0;
        note_xfer(ey, 1, a_first, a_col, a_px, a_py, push, ln);
        if (push) exp_a.push_back(ln);
    endtask

    task automatic send_b(input logic [23:0] d, input int ey, input int stall);
        int    guard = 0;
        bit    push;
        line_t ln;
        repeat (stall) @(negedge clk);
        bus_b.sample_data  = d;
        bus_b.sample_valid = 1'b1;
        while (!bus_b.sample_ready && guard < 200) begin @(negedge clk); guard++; end
        chk("b_ready_wait", 64'(guard < 200), 64'd1);
        if (guard >= 200) begin bus_b.sample_valid = 1'b0; return; end
        @(negedge clk);
        bus_b.sample_valid = 1'b0;
        note_xfer(ey, 4, b_first, b_col, b_px, b_py, push, ln);
        if (push) exp_b.push_back(ln);
    endtask

    task automatic start_frame_a();
        a_first = 1; a_col = 0; a_px = 0; a_py = 0;
        bus_a.frame_start = 1'b1;
        @(negedge clk);
        bus_a.frame_start = 1'b0;
    endtask

    // Line monitor and rasteriser model for instance A: line_done held ras_hold_a cycles.
    initial begin
        line_t exp;
        bus_a.line_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                ls_prev_a = 1'b0; ras_cnt_a = 0; bus_a.line_done = 1'b0;
            end else begin
                if (bus_a.line_start && !ls_prev_a) begin
                    lines_a++;
                    cur_a     = '{x1: bus_a.x1, y1: bus_a.y1, x2: bus_a.x2, y2: bus_a.y2};
                    last_x2_a = int'(bus_a.x2);
                    chk("a_line_pending", 64'(exp_a.size() > 0), 64'd1);
                    if (exp_a.size() > 0) begin
                        exp = exp_a.pop_front();
                        chk_line("a_line", cur_a, exp);
                    end
                    if (lat_chk_a) begin
                        chk("a_latency_edges", 64'(cyc - xfer_cyc_a + 1), 64'd2);
                        lat_chk_a = 1'b0;
                    end
                end
                if (bus_a.frame_done) begin
                    fd_a++;
                    chk("a_fd_busy", 64'(bus_a.busy), 64'd0);
                    chk("a_fd_done_low", 64'(bus_a.line_done), 64'd0);
                end
                if (ras_cnt_a > 0) begin
                    chk("a_held_quiet", 64'({bus_a.line_start, bus_a.sample_ready}), 64'd0);
                    chk_line("a_held_coords",
                             '{x1: bus_a.x1, y1: bus_a.y1, x2: bus_a.x2, y2: bus_a.y2}, cur_a);
                    ras_cnt_a--;
                    if (ras_cnt_a == 0) bus_a.line_done = 1'b0;
                end else if (ras_en_a && bus_a.line_start) begin
                    bus_a.line_done = 1'b1;
                    ras_cnt_a       = ras_hold_a;
                end
                ls_prev_a = bus_a.line_start;
            end
        end
    end

    initial begin
        line_t exp;
        bus_b.line_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                ls_prev_b = 1'b0; ras_cnt_b = 0; bus_b.line_done = 1'b0;
            end else begin
                if (bus_b.line_start && !ls_prev_b) begin
                    lines_b++;
                    cur_b = '{x1: 10'(bus_b.x1), y1: 10'(bus_b.y1), x2: 10'(bus_b.x2), y2: 10'(bus_b.y2)};
                    chk("b_line_pending", 64'(exp_b.size() > 0), 64'd1);
                    if (exp_b.size() > 0) begin
                        exp = exp_b.pop_front();
                        chk_line("b_line", cur_b, exp);
                    end
                end
                if (bus_b.frame_done) begin
                    fd_b++;
                    chk("b_fd_busy", 64'(bus_b.busy), 64'd0);
                end
                if (ras_cnt_b > 0) begin
                    chk("b_held_quiet", 64'({bus_b.line_start, bus_b.sample_ready}), 64'd0);
                    ras_cnt_b--;
                    if (ras_cnt_b == 0) bus_b.line_done = 1'b0;
                end else if (bus_b.line_start) begin
                    bus_b.line_done = 1'b1;
                    ras_cnt_b       = 1;
                end
                ls_prev_b = bus_b.line_start;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va[9];
        vec_t vb[4];
        int   n0;
        logic [23:0] d;

        va[0] = '{24'h000000, 240};
        va[1] = '{24'h010000, 239};
        va[2] = '{24'h7FFFFF, 113};
        va[3] = '{24'h800000, 368};
        va[4] = '{24'hFF0000, 241};
        va[5] = '{24'h123456, 222};
        va[6] = '{24'hC00000, 304};
        va[7] = '{24'h00FFFF, 240};
        va[8] = '{24'hFFFFFF, 241};
        vb[0] = '{24'h000000, 8};
        vb[1] = '{24'h000200, 0};
        vb[2] = '{24'hFFFFF0, 15};
        vb[3] = '{24'h000003, 5};

        bus_a.frame_start = 1'b0; bus_a.sample_valid = 1'b0; bus_a.sample_data = '0;
        bus_b.frame_start = 1'b0; bus_b.sample_valid = 1'b0; bus_b.sample_data = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_reset_ctrl", 64'({bus_a.line_start, bus_a.sample_ready, bus_a.busy, bus_a.frame_done}), 64'd0);
        chk("a_reset_coords", 64'({bus_a.x1, bus_a.y1, bus_a.x2, bus_a.y2}), 64'd0);
        chk("b_reset_ctrl", 64'({bus_b.line_start, bus_b.sample_ready, bus_b.busy, bus_b.frame_done}), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("a_idle_ready", 64'(bus_a.sample_ready), 64'd0);

        // Narrow screen, X_STEP=4, no amplitude shift: clamping both ways, 3 lines, stray frame_start.
        b_first = 1; b_col = 0; b_px = 0; b_py = 0;
        bus_b.frame_start = 1'b1;
        @(negedge clk);
        bus_b.frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_b(vb[i].sample, vb[i].exp_y, i);
            if (i == 1) begin
                bus_b.frame_start = 1'b1;
                @(negedge clk);
                bus_b.frame_start = 1'b0;
            end
        end
        for (int g = 0; g < 100 && fd_b == 0; g++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("b_frame_done_count", 64'(fd_b), 64'd1);
        chk("b_lines", 64'(lines_b), 64'd3);
        chk("b_busy_after", 64'({bus_b.busy, bus_b.sample_ready}), 64'd0);
        chk("b_queue_empty", 64'(exp_b.size()), 64'd0);

        // Default frame: table vectors with a slow rasteriser, then random samples to 640.
        ras_hold_a = 3;
        start_frame_a();
        chk("a_busy_on_start", 64'(bus_a.busy), 64'd1);
        for (int i = 0; i < 9; i++) begin
            if (i == 1) lat_chk_a = 1'b1;
            send_a(va[i].sample, va[i].exp_y, i % 3);
        end
        ras_hold_a = 1;
        for (int n = 9; n < 640; n++) begin
            d = 24'($urandom);
            send_a(d, model_y(d, 16, 480), $urandom_range(0, 2));
        end
        for (int g = 0; g < 100 && fd_a == 0; g++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("a_frame_done_count", 64'(fd_a), 64'd1);
        chk("a_lines", 64'(lines_a), 64'd639);
        chk("a_last_x2", 64'(last_x2_a), 64'd639);
        chk("a_busy_after", 64'({bus_a.busy, bus_a.sample_ready}), 64'd0);
        chk("a_queue_empty", 64'(exp_a.size()), 64'd0);

        // Reset while a request is outstanding, then a clean restart.
        ras_en_a = 1'b0;
        start_frame_a();
        send_a(24'h000000, 240, 0);
        send_a(24'h010000, 239, 0);
        for (int g = 0; g < 20 && !bus_a.line_start; g++) @(negedge clk);
        chk("a_ls_before_reset", 64'(bus_a.line_start), 64'd1);
        rst_a = 1'b1;
        @(negedge clk);
        chk("a_reset_midline", 64'({bus_a.line_start, bus_a.busy, bus_a.sample_ready}), 64'd0);
        rst_a    = 1'b0;
        ras_en_a = 1'b1;
        @(negedge clk);
        start_frame_a();
        n0 = lines_a;
        send_a(24'h7FFFFF, 113, 0);
        repeat (6) @(negedge clk);
        chk("a_first_no_line", 64'(lines_a), 64'(n0));
        send_a(24'h800000, 368, 1);
        for (int g = 0; g < 20 && lines_a == n0; g++) @(negedge clk);
        chk("a_restart_line", 64'(lines_a), 64'(n0 + 1));
        repeat (4) @(negedge clk);
        chk("a_queue_empty_end", 64'(exp_a.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
